// File: rtl/instr_fetch.sv
// Instruction fetch with loadable program memory.
// Loads a program word by word, then issues instructions by pc.
module instr_fetch #(
    parameter int          DEPTH     = 256,
    parameter int          AW        = 8,
    parameter logic [15:0] HALT_WORD = 16'hCFFF,
    parameter logic [15:0] NOP_WORD  = 16'hF000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_mode,
    input  logic          load_valid,
    input  logic [15:0]   load_data,
    output logic          load_ready,
    input  logic [15:0]   pc,
    output logic [15:0]   instruction,
    output logic [AW:0]   program_len,
    output logic          running,
    output logic          halted,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   len_q, len_d;
    logic [15:0]   instr_q, instr_d;
    logic          ovf_q, ovf_d;
    logic          run_q, halt_q;
    logic          in_load, has_room, wr_en, pc_ok;
    logic [15:0]   len_ext;
    logic [15:0]   mem [DEPTH];

    assign in_load  = (state_q == S_LOAD);
    assign has_room = (wptr_q < DEPTH_W);
    assign wr_en    = in_load && load_valid && has_room;

    // Full-width compare so any pc bit above AW counts as out of range.
    assign len_ext  = {{(15-AW){1'b0}}, len_q};
    assign pc_ok    = (pc < len_ext);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                instr_d = NOP_WORD;
                if (load_mode) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                instr_d = NOP_WORD;
                if (wr_en) begin
                    wptr_d = wptr_q + ONE_W;
                end
                if (load_valid && !has_room) begin
                    ovf_d = 1'b1;
                end
                if (!load_mode) begin
                    state_d = S_RUN;
                    len_d   = wptr_d;
                end
            end
            S_RUN: begin
                if (load_mode) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    instr_d = NOP_WORD;
                end else if (pc_ok) begin
                    instr_d = mem[pc[AW-1:0]];
                end else begin
                    instr_d = HALT_WORD;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (load_mode) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    instr_d = NOP_WORD;
                end else begin
                    instr_d = HALT_WORD;
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = NOP_WORD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            instr_q <= NOP_WORD;
            run_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            run_q   <= (state_d == S_RUN);
            halt_q  <= (state_d == S_HALT);
        end
    end

    // Contents survive reset; only the pointer and length are cleared.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wptr_q[AW-1:0]] <= load_data;
        end
    end

    assign load_ready  = in_load && has_room;
    assign instruction = instr_q;
    assign program_len = len_q;
    assign running     = run_q;
    assign halted      = halt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_mode;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [8:0]  program_len;
    logic        running;
    logic        halted;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .load_mode   (load_mode),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .pc          (pc),
        .instruction (instruction),
        .program_len (program_len),
        .running     (running),
        .halted      (halted),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; load_mode = 1'b0; load_valid = 1'b0;
        load_data = 16'h0; pc = 16'h0;
        tick();
        tick();
        check("rst_instr", instruction, 16'hF000);
        check("rst_ready", load_ready, 0);
        check("rst_run", running, 0);
        check("rst_halt", halted, 0);
        check("rst_ovf", overflow, 0);
        check("rst_len", program_len, 0);

        // three-word program, final word accepted on the exit edge
        reset = 1'b1; load_mode = 1'b1;
        tick();
        check("load_ready", load_ready, 1);
        check("load_instr", instruction, 16'hF000);
        load_valid = 1'b1; load_data = 16'h0105;
        tick();
        load_data = 16'h2110;
        tick();
        load_data = 16'h1100; load_mode = 1'b0; pc = 16'd1;
        tick();
        load_valid = 1'b0;
        check("r21_len", program_len, 3);
        check("r21_run", running, 1);
        check("r21_ready", load_ready, 0);
        tick();
        check("r21_pc1", instruction, 16'h2110);
        pc = 16'd0;
        tick();
        check("pc0", instruction, 16'h0105);
        pc = 16'd2;
        tick();
        check("pc2", instruction, 16'h1100);

        pc = 16'd3;
        tick();
        check("r22_instr", instruction, 16'hCFFF);
        check("r22_halt", halted, 1);
        check("r22_run", running, 0);
        pc = 16'd0;
        tick();
        check("r22_hold_halt", halted, 1);
        check("r22_hold_instr", instruction, 16'hCFFF);

        // reload from HALT
        load_mode = 1'b1;
        tick();
        check("r26_instr_nop", instruction, 16'hF000);
        check("r26_len_clr", program_len, 0);
        check("r26_halt_clr", halted, 0);
        load_valid = 1'b1; load_data = 16'h0207; load_mode = 1'b0;
        tick();
        load_valid = 1'b0;
        check("r26_len", program_len, 1);
        pc = 16'd0;
        tick();
        check("r26_instr", instruction, 16'h0207);
        check("r26_run", running, 1);

        // pc bits above AW are out of range even though pc[7:0]==0
        pc = 16'h0100;
        tick();
        check("hi_pc_instr", instruction, 16'hCFFF);
        check("hi_pc_halt", halted, 1);

        // RUN -> LOAD interrupts issue with a NOP
        load_mode = 1'b1;
        tick();
        load_valid = 1'b1; load_data = 16'h1234; load_mode = 1'b0;
        tick();
        load_valid = 1'b0; pc = 16'd0;
        tick();
        check("reload_instr", instruction, 16'h1234);
        load_mode = 1'b1;
        tick();
        check("r14_instr", instruction, 16'hF000);
        check("r14_run", running, 0);
        check("r14_ready", load_ready, 1);
        check("r14_len", program_len, 0);

        // fill memory and offer one extra word
        load_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_data = 16'(i + 1);
            tick();
        end
        check("r23_ready_full", load_ready, 0);
        check("r23_ovf_pre", overflow, 0);
        load_data = 16'hBEEF;
        tick();
        check("r23_ovf", overflow, 1);
        load_valid = 1'b0; load_mode = 1'b0; pc = 16'd255;
        tick();
        check("r23_len", program_len, 256);
        check("r23_ovf_sticky", overflow, 1);
        tick();
        check("r23_mem255", instruction, 16'h0100);
        pc = 16'd0;
        tick();
        check("r23_mem0", instruction, 16'h0001);
        pc = 16'd256;
        tick();
        check("r23_pc256", halted, 1);

        // empty program halts on first RUN edge
        load_mode = 1'b1;
        tick();
        check("r24_ovf_clr", overflow, 0);
        load_mode = 1'b0;
        tick();
        check("r24_len", program_len, 0);
        check("r24_run", running, 1);
        tick();
        check("r24_halt", halted, 1);
        check("r24_instr", instruction, 16'hCFFF);

        // reset in the middle of a load
        load_mode = 1'b1;
        tick();
        load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_data = 16'(16'hA000 + i);
            tick();
        end
        reset = 1'b0; load_data = 16'hA005;
        tick();
        check("r25_ready", load_ready, 0);
        check("r25_len", program_len, 0);
        check("r25_instr", instruction, 16'hF000);
        check("r25_run", running, 0);
        check("r25_halt", halted, 0);

        // IDLE with load_mode low goes to RUN, length 0 halts
        reset = 1'b1; load_valid = 1'b0; load_mode = 1'b0;
        tick();
        check("idle_run", running, 1);
        tick();
        check("idle_halt", halted, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
